// File: rtl/bcd_display_ctrl_if.sv
// Bus between the binary result source and the BCD display controller.
// The master side (application datapath or bench) drives the request and the
// blanking option. The slave side (the controller) returns the handshake, the
// BCD result and the multiplexed display drive.
interface bcd_display_ctrl_if #(
  parameter int BIN_W = 13
);
  logic [BIN_W-1:0] value;
  logic             load;
  logic             blank_lz;
  logic             busy;
  logic             done;
  logic [3:0]       bcd0;
  logic [3:0]       bcd1;
  logic [3:0]       bcd2;
  logic [3:0]       bcd3;
  logic [3:0]       an;
  logic [3:0]       digit;

  modport master (
    output value, load, blank_lz,
    input  busy, done, bcd0, bcd1, bcd2, bcd3, an, digit
  );

  modport slave (
    input  value, load, blank_lz,
    output busy, done, bcd0, bcd1, bcd2, bcd3, an, digit
  );
endinterface

// File: rtl/bcd_display_ctrl.sv
// Binary to BCD converter (double dabble, one shift per clock) feeding a
// multiplexed 4-digit 7-segment display scanner with leading-zero blanking.
// The last shift writes the shift register and the BCD output registers on the
// same edge, so the outputs only ever change from one full result to the next.
module bcd_display_ctrl #(
  parameter int BIN_W    = 13,
  parameter int SCAN_DIV = 50000
) (
  input logic               clk,
  input logic               rst_n,
  bcd_display_ctrl_if.slave bus
);

  localparam int BCD_W = 16;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(SCAN_DIV);

  localparam logic [3:0]       LAST_SHIFT = 4'(BIN_W - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Conversion state
  state_t            state_reg, state_next;
  logic [SR_W-1:0]   sr_reg, sr_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              done_reg, done_next;
  logic              bcd_load;
  logic [3:0][3:0]   bcd_reg;

  // Add-3 correction applied to every BCD nibble, then the left shift
  logic [SR_W-1:0]   sr_adj;
  logic [SR_W-1:0]   sr_shift;
  logic              unused_sr_top;

  // Display scan state
  logic [CNT_W-1:0]  scan_cnt_reg;
  logic [1:0]        scan_idx_reg;
  logic [3:0]        an_reg;
  logic [3:0]        digit_reg;
  logic              scan_wrap;
  logic [1:0]        scan_idx_next;
  logic [3:0]        an_next;
  logic [3:0]        zero_from;
  logic [3:0]        blank_mask;

  genvar gi;

  // Nibbles >= 5 get +3 so the following shift carries correctly into the next decade
  generate
    for (gi = 0; gi < 4; gi++) begin : g_add3
      logic [3:0] nib;
      assign nib = sr_reg[BIN_W + 4*gi +: 4];
      assign sr_adj[BIN_W + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  assign sr_adj[BIN_W-1:0] = sr_reg[BIN_W-1:0];
  assign sr_shift          = {sr_adj[SR_W-2:0], 1'b0};
  // The top bit shifted out is always zero for inputs up to 8191
  assign unused_sr_top     = sr_adj[SR_W-1];

  // Conversion FSM register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      bcd_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      if (bcd_load) begin
        bcd_reg <= sr_shift[SR_W-1 -: BCD_W];
      end
    end
  end

  // Conversion FSM next state: accept a load in IDLE, shift BIN_W times in SHIFT
  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    bcd_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.load) begin
          sr_next    = {{BCD_W{1'b0}}, bus.value};
          cnt_next   = 4'd0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        sr_next  = sr_shift;
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == LAST_SHIFT) begin
          bcd_load   = 1'b1;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A digit above the units is blank when it and every higher digit are zero
  generate
    for (gi = 1; gi < 4; gi++) begin : g_blank
      assign zero_from[gi]  = (bcd_reg[3:gi] == '0);
      assign blank_mask[gi] = bus.blank_lz & zero_from[gi];
    end
  endgenerate

  assign zero_from[0]  = 1'b0;
  assign blank_mask[0] = 1'b0;

  // Next scan slot and its anode pattern, computed from the registered result
  always_comb begin
    scan_wrap     = (scan_cnt_reg == SCAN_LAST);
    scan_idx_next = scan_idx_reg + 2'd1;
    an_next       = ~(4'b0001 << scan_idx_next);
    if (blank_mask[scan_idx_next]) begin
      an_next = 4'b1111;
    end
  end

  // Free-running scan: each digit stays active for SCAN_DIV clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_reg <= '0;
      scan_idx_reg <= 2'd0;
      an_reg       <= 4'b1110;
      digit_reg    <= 4'd0;
    end else if (scan_wrap) begin
      scan_cnt_reg <= '0;
      scan_idx_reg <= scan_idx_next;
      an_reg       <= an_next;
      digit_reg    <= bcd_reg[scan_idx_next];
    end else begin
      scan_cnt_reg <= scan_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.busy  = (state_reg == SHIFT);
  assign bus.done  = done_reg;
  assign bus.bcd0  = bcd_reg[0];
  assign bus.bcd1  = bcd_reg[1];
  assign bus.bcd2  = bcd_reg[2];
  assign bus.bcd3  = bcd_reg[3];
  assign bus.an    = an_reg;
  assign bus.digit = digit_reg;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl with a short scan period (SCAN_DIV=4).
module tb_bcd_display_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  bcd_display_ctrl_if #(.BIN_W(13)) bus ();

  bcd_display_ctrl #(
    .BIN_W    (13),
    .SCAN_DIV (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; samples and drives happen 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] bcd_all();
    return {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
  endfunction

  // One conversion; optionally a second load is attempted at cycle second_at
  task automatic run_conv(input string tag, input logic [12:0] v,
                          input logic [15:0] exp_bcd, input int second_at);
    logic [15:0] prev;
    int dcnt, dcyc, bcnt, stab;
    prev = bcd_all();
    dcnt = 0; dcyc = 0; bcnt = 0; stab = 0;
    bus.value = v;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
    bus.value = 13'($urandom);
    check({tag, "_busy0"}, 32'(bus.busy), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      if (i == second_at) begin
        bus.load  = 1'b1;
        bus.value = 13'd42;
      end else begin
        bus.load = 1'b0;
      end
      tick();
      if (bus.done === 1'b1) begin
        dcnt++;
        dcyc = i;
      end
      if (bus.busy === 1'b1) bcnt++;
      if (dcnt == 0 && bcd_all() !== prev) stab++;
    end
    bus.load = 1'b0;
    $display("conv %s value=%0d bcd=%h done_cycle=%0d", tag, v, bcd_all(), dcyc);
    check({tag, "_done_count"}, 32'(dcnt), 32'd1);
    check({tag, "_done_cycle"}, 32'(dcyc), 32'd13);
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'd12);
    check({tag, "_bcd"}, 32'(bcd_all()), 32'(exp_bcd));
    check({tag, "_stable"}, 32'(stab), 32'd0);
  endtask

  // Align to the start of slot 1, then check slots 1,2,3,0 for 4 cycles each
  task automatic scan_slots(input string tag, input logic [15:0] an_seq,
                            input logic [15:0] dig_seq);
    int n;
    int s;
    n = 0;
    while (bus.an !== 4'b1110 && n < 40) begin tick(); n++; end
    while (bus.an === 4'b1110 && n < 40) begin tick(); n++; end
    check({tag, "_sync"}, 32'(n < 40), 32'd1);
    for (int k = 0; k < 4; k++) begin
      s = (k + 1) % 4;
      $display("scan %s slot=%0d an=%b digit=%0d", tag, s, bus.an, bus.digit);
      for (int c = 0; c < 4; c++) begin
        check($sformatf("%s_an_s%0d_c%0d", tag, s, c), 32'(bus.an), 32'(an_seq[4*s +: 4]));
        check($sformatf("%s_dig_s%0d_c%0d", tag, s, c), 32'(bus.digit), 32'(dig_seq[4*s +: 4]));
        tick();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [12:0] b2b_val [3];
    logic [15:0] b2b_exp [3];
    logic [15:0] prev;
    int dcyc, stab, dcnt;

    n_checks = 0;
    n_pass   = 0;
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.blank_lz = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bcd", 32'(bcd_all()), 32'h0);
    check("rst_an", 32'(bus.an), 32'b1110);
    check("rst_digit", 32'(bus.digit), 32'd0);
    $display("reset busy=%b done=%b an=%b", bus.busy, bus.done, bus.an);
    rst_n = 1'b1;
    tick();

    // Maximum value
    run_conv("conv_8191", 13'd8191, 16'h8191, 0);

    // Back-to-back conversions with load held high
    b2b_val = '{13'd0, 13'd9, 13'd1000};
    b2b_exp = '{16'h0000, 16'h0009, 16'h1000};
    prev = 16'h8191;
    bus.load = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus.value = b2b_val[j];
      tick();
      bus.value = 13'($urandom);
      check($sformatf("b2b%0d_busy0", j), 32'(bus.busy), 32'd1);
      dcyc = 0;
      stab = 0;
      for (int i = 1; i <= 13; i++) begin
        tick();
        if (bus.done === 1'b1 && dcyc == 0) dcyc = i;
        if (i < 13 && bcd_all() !== prev) stab++;
      end
      $display("b2b value=%0d bcd=%h done_cycle=%0d", b2b_val[j], bcd_all(), dcyc);
      check($sformatf("b2b%0d_done_cycle", j), 32'(dcyc), 32'd13);
      check($sformatf("b2b%0d_bcd", j), 32'(bcd_all()), 32'(b2b_exp[j]));
      check($sformatf("b2b%0d_stable", j), 32'(stab), 32'd0);
      prev = b2b_exp[j];
    end
    bus.load = 1'b0;
    tick();
    check("b2b_done_pulse_end", 32'(bus.done), 32'd0);
    check("b2b_idle", 32'(bus.busy), 32'd0);

    // Load while busy is ignored
    run_conv("ignore_load", 13'd1234, 16'h1234, 5);

    // Plain scan of 1234
    bus.blank_lz = 1'b0;
    scan_slots("scan_1234", {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 16'h1234);

    // Leading-zero blanking
    bus.blank_lz = 1'b1;
    run_conv("conv_42", 13'd42, 16'h0042, 0);
    scan_slots("blank_42", {4'b1111, 4'b1111, 4'b1101, 4'b1110}, 16'h0042);
    run_conv("conv_0", 13'd0, 16'h0000, 0);
    scan_slots("blank_0", {4'b1111, 4'b1111, 4'b1111, 4'b1110}, 16'h0000);
    bus.blank_lz = 1'b0;

    // Reset in the middle of a conversion
    run_conv("conv_42b", 13'd42, 16'h0042, 0);
    bus.value = 13'd1234;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_bcd", 32'(bcd_all()), 32'h0);
    check("mid_rst_an", 32'(bus.an), 32'b1110);
    check("mid_rst_digit", 32'(bus.digit), 32'd0);
    $display("mid-conversion reset busy=%b bcd=%h an=%b", bus.busy, bcd_all(), bus.an);
    tick();
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done === 1'b1) dcnt++;
    end
    check("mid_rst_no_done", 32'(dcnt), 32'd0);
    run_conv("after_rst", 13'd1234, 16'h1234, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
